// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader and its neighbours
// (fetch, decode, pipeline top).
package inst_loader_pkg;

    localparam int INST_LEN   = 17;
    localparam int INST_CAP   = 5;
    localparam int IMEM_WORDS = 1 << INST_CAP;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/inst_loader_sync_fifo.sv
// Small synchronous FIFO with a combinational head; pointers carry one
// extra wrap bit so full and empty can be told apart.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty     = (r_wp == r_rp);
    assign full      = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign dout      = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + 1'b1;
            if (w_pop_ok)  r_rp <= r_rp + 1'b1;
        end
    end

    // Storage carries no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/inst_loader.sv
// Streams a program into instruction memory through a small FIFO and holds
// the core in reset until every word has been written.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int INST_LEN = inst_loader_pkg::INST_LEN,
    parameter int INST_CAP = inst_loader_pkg::INST_CAP,
    parameter int FIFO_AW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [INST_LEN-1:0] s_data,
    input  logic                s_last,
    input  logic                im_busy,
    output logic                im_we,
    output logic [INST_CAP-1:0] im_addr,
    output logic [INST_LEN-1:0] im_wdata,
    output logic                core_rstn,
    output logic                done,
    output logic                err,
    output logic [INST_CAP:0]   count
);

    localparam logic [INST_CAP:0] L_WORDS    = {1'b1, {INST_CAP{1'b0}}};
    localparam logic [INST_CAP:0] L_LAST_ACC = L_WORDS - 1'b1;

    state_t                r_state;
    state_t                w_state_next;
    logic [INST_CAP:0]     r_acc;
    logic [INST_CAP-1:0]   r_wptr;
    logic [INST_CAP:0]     r_count;
    logic                  r_im_we;
    logic [INST_CAP-1:0]   r_im_addr;
    logic [INST_LEN-1:0]   r_im_wdata;
    logic                  r_core_rstn;
    logic                  r_done;
    logic                  r_err;

    logic                  w_s_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_cap_hit;
    logic                  w_full;
    logic                  w_empty;
    logic [INST_LEN-1:0]   w_head;

    sync_fifo #(
        .WIDTH (INST_LEN),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (s_data),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_state_next = r_state;
        w_s_ready    = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_s_ready = !w_full && (r_acc < L_WORDS);
                w_pop     = !w_empty && !im_busy;
                if (w_s_ready && s_valid && (s_last || w_cap_hit))
                    w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_pop = !w_empty && !im_busy;
                // Wait for the final write to retire before releasing the core.
                if (w_empty && !r_im_we) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_push    = s_valid && w_s_ready;
    assign w_cap_hit = (r_acc == L_LAST_ACC);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_core_rstn <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_core_rstn <= (w_state_next == ST_RUN);
            r_done      <= (w_state_next == ST_RUN);
            if (r_state == ST_IDLE && start) r_acc <= '0;
            else if (w_push)                 r_acc <= r_acc + 1'b1;
            // A full-capacity program without s_last is truncated and flagged.
            if (w_push && !s_last && w_cap_hit) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_count    <= '0;
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
        end else begin
            r_im_we <= w_pop;
            if (r_state == ST_IDLE && start) begin
                r_wptr  <= '0;
                r_count <= '0;
            end else if (w_pop) begin
                r_im_addr  <= r_wptr;
                r_im_wdata <= w_head;
                r_wptr     <= r_wptr + 1'b1;
                r_count    <= r_count + 1'b1;
            end
        end
    end

    assign s_ready   = w_s_ready;
    assign im_we     = r_im_we;
    assign im_addr   = r_im_addr;
    assign im_wdata  = r_im_wdata;
    assign core_rstn = r_core_rstn;
    assign done      = r_done;
    assign err       = r_err;
    assign count     = r_count;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: cycle table for basic and single-word
// loads, plus hand sequences for backpressure, overflow, reset and start.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [16:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        im_busy = 1'b0;
    logic        im_we;
    logic [4:0]  im_addr;
    logic [16:0] im_wdata;
    logic        core_rstn;
    logic        done;
    logic        err;
    logic [5:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0]  wa [$];
    logic [16:0] wd [$];

    typedef struct packed {
        logic        rdy;
        logic        we;
        logic [4:0]  addr;
        logic [16:0] wdata;
        logic        rstn;
        logic        dn;
        logic        er;
        logic [5:0]  cnt;
    } outs_t;

    typedef struct {
        logic        rst;
        logic        start;
        logic        valid;
        logic [16:0] data;
        logic        last;
        logic        busy;
        outs_t       exp;
    } vec_t;

    vec_t tbl [16];

    inst_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .im_busy   (im_busy),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .core_rstn (core_rstn),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wa.push_back(im_addr);
            wd.push_back(im_wdata);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    function automatic vec_t mkv(input logic r, st, vl, input logic [16:0] d,
                                 input logic ls, bz, rdy, we, input logic [4:0] a,
                                 input logic [16:0] wdt, input logic rn, dn, er,
                                 input logic [5:0] cnt);
        vec_t v;
        v.rst = r; v.start = st; v.valid = vl; v.data = d; v.last = ls; v.busy = bz;
        v.exp = '{rdy: rdy, we: we, addr: a, wdata: wdt, rstn: rn, dn: dn, er: er, cnt: cnt};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; im_busy = 1'b0;
        tick();
        rst = 1'b0;
        wa.delete();
        wd.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_beats(input int first, input int total, input bit mark_last,
                              input logic [16:0] base, input int budget, output int got);
        int cyc = 0;
        got = first;
        while (got < total && cyc < budget) begin
            s_valid = 1'b1;
            s_data  = base + 17'(got);
            s_last  = mark_last && (got == total - 1);
            #2;
            if (s_ready === 1'b1) got++;
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_run(input int budget);
        int cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
        chk("reach_run", done, 1);
        chk("core_rstn_run", core_rstn, 1);
    endtask

    task automatic check_writes(input string tag, input int n, input logic [16:0] base);
        chk({tag, "_nwrites"}, wa.size(), n);
        for (int i = 0; i < n && i < wa.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wa[i], i);
            chk($sformatf("%s_data%0d", tag, i), wd[i], base + 17'(i));
        end
    endtask

    initial begin
        int got;
        outs_t act;

        // rst st vl data      ls bz | rdy we addr wdata    rn dn er cnt
        tbl[0]  = mkv(0, 1, 0, 17'h00000, 0, 0,  0, 0, 5'd0, 17'h00000, 0, 0, 0, 6'd0);
        tbl[1]  = mkv(0, 0, 1, 17'h00011, 0, 0,  1, 0, 5'd0, 17'h00000, 0, 0, 0, 6'd0);
        tbl[2]  = mkv(0, 0, 1, 17'h00022, 0, 0,  1, 0, 5'd0, 17'h00000, 0, 0, 0, 6'd0);
        tbl[3]  = mkv(0, 0, 1, 17'h10033, 1, 0,  1, 1, 5'd0, 17'h00011, 0, 0, 0, 6'd1);
        tbl[4]  = mkv(0, 0, 0, 17'h00000, 0, 0,  0, 1, 5'd1, 17'h00022, 0, 0, 0, 6'd2);
        tbl[5]  = mkv(0, 0, 0, 17'h00000, 0, 0,  0, 1, 5'd2, 17'h10033, 0, 0, 0, 6'd3);
        tbl[6]  = mkv(0, 0, 0, 17'h00000, 0, 0,  0, 0, 5'd2, 17'h10033, 0, 0, 0, 6'd3);
        tbl[7]  = mkv(0, 1, 1, 17'h00005, 1, 0,  0, 0, 5'd2, 17'h10033, 1, 1, 0, 6'd3);
        tbl[8]  = mkv(0, 0, 1, 17'h00006, 0, 0,  0, 0, 5'd2, 17'h10033, 1, 1, 0, 6'd3);
        tbl[9]  = mkv(1, 0, 0, 17'h00000, 0, 0,  0, 0, 5'd2, 17'h10033, 1, 1, 0, 6'd3);
        tbl[10] = mkv(0, 1, 0, 17'h00000, 0, 0,  0, 0, 5'd0, 17'h00000, 0, 0, 0, 6'd0);
        tbl[11] = mkv(0, 0, 1, 17'h1FFFF, 1, 0,  1, 0, 5'd0, 17'h00000, 0, 0, 0, 6'd0);
        tbl[12] = mkv(0, 0, 0, 17'h00000, 0, 0,  0, 0, 5'd0, 17'h00000, 0, 0, 0, 6'd0);
        tbl[13] = mkv(0, 0, 0, 17'h00000, 0, 0,  0, 1, 5'd0, 17'h1FFFF, 0, 0, 0, 6'd1);
        tbl[14] = mkv(0, 0, 0, 17'h00000, 0, 0,  0, 0, 5'd0, 17'h1FFFF, 0, 0, 0, 6'd1);
        tbl[15] = mkv(0, 0, 0, 17'h00000, 0, 0,  0, 0, 5'd0, 17'h1FFFF, 1, 1, 0, 6'd1);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst; start = tbl[i].start; s_valid = tbl[i].valid;
            s_data = tbl[i].data; s_last = tbl[i].last; im_busy = tbl[i].busy;
            #2;
            act = '{rdy: s_ready, we: im_we, addr: im_addr, wdata: im_wdata,
                    rstn: core_rstn, dn: done, er: err, cnt: count};
            chk($sformatf("vec%0d", i), act, tbl[i].exp);
            tick();
        end
        rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;

        // Backpressure: memory busy, FIFO fills at four beats.
        do_reset();
        im_busy = 1'b1;
        do_start();
        push_beats(0, 6, 1'b1, 17'h0A000, 10, got);
        chk("bp_accepted_busy", got, 4);
        chk("bp_ready_low", s_ready, 0);
        chk("bp_no_we_busy", wa.size(), 0);
        im_busy = 1'b0;
        push_beats(4, 6, 1'b1, 17'h0A000, 20, got);
        chk("bp_accepted_all", got, 6);
        wait_run(40);
        check_writes("bp", 6, 17'h0A000);
        chk("bp_count", count, 6);
        chk("bp_err", err, 0);

        // Overflow: 33 beats offered without s_last.
        do_reset();
        do_start();
        push_beats(0, 33, 1'b0, 17'h05500, 45, got);
        chk("ov_accepted", got, 32);
        chk("ov_ready_low", s_ready, 0);
        wait_run(40);
        chk("ov_err", err, 1);
        chk("ov_count", count, 32);
        check_writes("ov", 32, 17'h05500);

        // Reset in the middle of a load.
        do_reset();
        do_start();
        push_beats(0, 2, 1'b0, 17'h03300, 5, got);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_im_we", im_we, 0);
        chk("mr_count", count, 0);
        chk("mr_core_rstn", core_rstn, 0);
        chk("mr_ready", s_ready, 0);
        chk("mr_done", done, 0);
        wa.delete();
        wd.delete();
        tick(); tick(); tick();
        chk("mr_no_we_after", wa.size(), 0);
        do_start();
        push_beats(0, 2, 1'b1, 17'h07700, 8, got);
        chk("mr_accepted", got, 2);
        wait_run(20);
        check_writes("mr", 2, 17'h07700);
        chk("mr_count_final", count, 2);

        // start during LOAD and RUN is ignored.
        do_reset();
        do_start();
        push_beats(0, 2, 1'b0, 17'h01200, 5, got);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("is_count_load", count, 2);
        push_beats(2, 4, 1'b1, 17'h01200, 8, got);
        wait_run(20);
        check_writes("is", 4, 17'h01200);
        start = 1'b1;
        s_valid = 1'b1;
        s_data = 17'h0ABCD;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("is_run_ready%0d", k), s_ready, 0);
            tick();
        end
        start = 1'b0;
        s_valid = 1'b0;
        tick(); tick();
        chk("is_run_count", count, 4);
        chk("is_run_nwrites", wa.size(), 4);
        chk("is_run_done", done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Upstream neighbour of the instruction-fetch stage.
- Accepts a valid/ready stream of INST_LEN-bit instructions from a host or testbench and buffers it in a small FIFO.
- Writes the instructions sequentially into the fetch stage's instruction memory.
- Holds the pipeline core in reset via core_rstn until loading completes, then releases it so fetch starts from address 0.

Parameters:
- INST_LEN, 17, instruction width in bits.
- INST_CAP, 5, instruction-memory address width; capacity is 2^INST_CAP words.
- FIFO_AW, 2, FIFO address width; depth is 2^FIFO_AW = 4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE.
- s_valid  in  1  stream beat valid.
- s_ready  out  1  stream beat ready; a beat transfers when s_valid and s_ready are both high at a clk edge.
- s_data  in  INST_LEN  instruction word.
- s_last  in  1  marks the final instruction of the program.
- im_busy  in  1  instruction memory cannot accept a write this cycle.
- im_we  out  1  instruction-memory write enable (registered).
- im_addr  out  INST_CAP  write address (registered).
- im_wdata  out  INST_LEN  write data (registered).
- core_rstn  out  1  active-low reset to the pipeline core (registered).
- done  out  1  high while in RUN.
- err  out  1  sticky; program exceeded capacity without s_last.
- count  out  INST_CAP+1  number of instructions written into instruction memory.

Behaviour:
- Reset values: state IDLE, s_ready 0, im_we 0, im_addr 0, im_wdata 0, core_rstn 0, done 0, err 0, count 0, FIFO empty.
- FSM is IDLE -> LOAD -> DRAIN -> RUN:
  - IDLE: core held in reset, s_ready 0. start=1 moves to LOAD and clears the accept counter, write pointer and count.
  - LOAD: s_ready = !fifo_full && (accepted < 2^INST_CAP).
    - An accepted beat with s_last=1 moves to DRAIN on the same edge.
    - If the 2^INST_CAP-th accepted beat has s_last=0: set err=1 and move to DRAIN; that beat is treated as the last.
  - DRAIN: s_ready 0. When the FIFO is empty and im_we is 0, move to RUN.
  - RUN: core_rstn=1 and done=1, both registered, so they rise on the edge that enters RUN. All inputs except rst are ignored; s_ready 0.
- Write path, active in LOAD and DRAIN:
  - Each cycle with FIFO not empty and im_busy=0: pop the head.
  - On the same edge, register im_we=1, im_addr=write pointer, im_wdata=head; then increment the write pointer and count.
  - Otherwise im_we=0 on the next edge; im_addr and im_wdata hold.
- Latency: a beat accepted at edge k into an empty FIFO appears on im_* during the cycle after edge k+1, provided im_busy=0.
- Throughput: one write per cycle.
- im_busy stalls the pop only. The FIFO absorbs up to 4 beats, then s_ready falls.
- FIFO rules:
  - Push is allowed only when not full, based on registered full.
  - Simultaneous push and pop is legal when not full; occupancy is unchanged.
  - Pointers wrap modulo 2^FIFO_AW, with an extra bit to distinguish full from empty.
- The write pointer never wraps: the capacity check guarantees at most 2^INST_CAP writes. count reaches 2^INST_CAP exactly, hence INST_CAP+1 bits.
- start outside IDLE is ignored.
- rst at any time, including mid-load or mid-DRAIN:
  - All state returns to reset values on that edge and the FIFO is flushed.
  - Any partially written instruction memory is left as is; no im_we is issued after the reset edge.

Decomposition:
- Shared package holds:
  - state enum (IDLE, LOAD, DRAIN, RUN);
  - INST_LEN and INST_CAP defaults, shared with the fetch, decode and pipeline top;
  - derived constant IMEM_WORDS = 2^INST_CAP.
- One sub-module, sync_fifo:
  - parameters WIDTH and AW;
  - ports clk, rst, push, pop, din, dout (combinational head), full, empty.
- inst_loader instantiates sync_fifo with WIDTH=INST_LEN, AW=FIFO_AW and contains the FSM and write-path registers.

Test Plan:
- Basic load: rst; start; stream 3 beats 0x00011, 0x00022, 0x10033 (last on the third), s_valid held high, im_busy=0.
  -> im writes addr 0/1/2 with those values on consecutive cycles; count=3; core_rstn and done rise the edge after the last im_we falls; err=0.
- Backpressure: stream 6 beats with im_busy=1 throughout, then drop im_busy.
  -> s_ready falls after 4 accepted beats and no im_we occurs while busy; after release all 6 are written to addr 0..5 in order; count=6.
- Overflow: stream 33 beats, none with s_last.
  -> exactly 32 accepted; s_ready 0 afterwards; addr 0..31 written; err=1; count=32; RUN reached.
- Reset mid-load: after 2 of 5 beats are accepted, assert rst for one cycle.
  -> next cycle state IDLE, im_we=0, count=0, core_rstn=0; a fresh start and 2-beat stream writes addr 0..1 correctly.
- Ignored start: pulse start during LOAD and during RUN, and drive s_valid in RUN.
  -> no counter clear, s_ready stays 0 in RUN, no im_we.
- Single-instruction program: one beat 0x1FFFF with s_last=1.
  -> im_addr=0, im_wdata=0x1FFFF, count=1, done=1.
